// File: rtl/osd_regaccess_pkg.sv
// Shared definitions for the debug register-access protocol: flit layout,
// packet types and register addresses used by initiators and responders.
package osd_regaccess_pkg;

  localparam int unsigned FLIT_W   = 16;
  localparam int unsigned ID_W     = 10;
  localparam int unsigned TYPE_W   = 4;
  localparam int unsigned TYPE_LSB = 12;
  localparam int unsigned ID_LSB   = 0;

  localparam logic [TYPE_W-1:0] REQ_READ_REG = 4'b0010;

  localparam logic [FLIT_W-1:0] REG_MODID   = 16'h0000;
  localparam logic [FLIT_W-1:0] REG_VERSION = 16'h0001;

  // One flit on a debug interconnect channel (ready travels the other way)
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [FLIT_W-1:0] data;
  } dii_flit_t;

  function automatic logic [ID_W-1:0] flit_id(input logic [FLIT_W-1:0] flit);
    return flit[ID_LSB +: ID_W];
  endfunction

  function automatic logic [FLIT_W-1:0] hdr_flit(input logic [TYPE_W-1:0] ptype,
                                                 input logic [ID_W-1:0]   src);
    return {ptype, 2'b00, src};
  endfunction

endpackage

// File: rtl/osd_regread_initiator.sv
// Issues one REQ_READ_REG packet and collects the 3-flit response.
// Optional response timeout enabled with OSD_REGREAD_TIMEOUT_EN.
module osd_regread_initiator
  import osd_regaccess_pkg::*;
`ifdef OSD_REGREAD_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   id,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_dest,
  input  logic [FLIT_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FLIT_W-1:0] rsp_value,
  output logic              rsp_err,
  output dii_flit_t         debug_out,
  input  logic              debug_out_ready,
  input  dii_flit_t         debug_in,
  output logic              debug_in_ready
);

  typedef enum logic [3:0] {
    IDLE, REQ_DEST, REQ_HDR, REQ_ADDR, RSP_DEST, RSP_SRC, RSP_VAL, DROP, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   dest_q, dest_nxt;
  logic [FLIT_W-1:0] addr_q, addr_nxt, value_nxt;
  logic              err_nxt, mis_q, mis_nxt;
  logic              req_ready_nxt, rsp_valid_nxt, in_ready_nxt;
  dii_flit_t         out_nxt;
  logic              in_xfer;

`ifdef OSD_REGREAD_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_nxt;
`endif

  assign in_xfer = debug_in.valid & debug_in_ready;

  // Next state plus next values of every registered output
  always_comb begin
    state_nxt = state;
    dest_nxt  = dest_q;
    addr_nxt  = addr_q;
    value_nxt = rsp_value;
    err_nxt   = rsp_err;
    mis_nxt   = mis_q;
`ifdef OSD_REGREAD_TIMEOUT_EN
    timer_nxt = '0;
`endif

    case (state)
      IDLE: if (req_valid) begin
        dest_nxt  = req_dest;
        addr_nxt  = req_addr;
        state_nxt = REQ_DEST;
      end
      REQ_DEST: if (debug_out_ready) state_nxt = REQ_HDR;
      REQ_HDR:  if (debug_out_ready) state_nxt = REQ_ADDR;
      REQ_ADDR: if (debug_out_ready) begin
        state_nxt = RSP_DEST;
        value_nxt = '0;
      end
      RSP_DEST: if (in_xfer) begin
        mis_nxt = (flit_id(debug_in.data) != id);
        if (debug_in.last) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = RSP_SRC;
        end
      end
      RSP_SRC: if (in_xfer) begin
        mis_nxt = mis_q | (flit_id(debug_in.data) != dest_q);
        if (debug_in.last) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = RSP_VAL;
        end
      end
      RSP_VAL: if (in_xfer) begin
        if (debug_in.last) begin
          err_nxt   = mis_q;
          value_nxt = mis_q ? '0 : debug_in.data;
          state_nxt = DONE;
        end else begin
          err_nxt   = 1'b1;
          value_nxt = '0;
          state_nxt = DROP;
        end
      end
      DROP: if (in_xfer && debug_in.last) state_nxt = DONE;
      DONE: if (rsp_ready) begin
        err_nxt   = 1'b0;
        mis_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef OSD_REGREAD_TIMEOUT_EN
    // Timer restarts on every accepted flit; zero outside the wait states
    if (state inside {RSP_DEST, RSP_SRC, RSP_VAL, DROP}) begin
      if (in_xfer) begin
        timer_nxt = '0;
      end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
        err_nxt   = 1'b1;
        value_nxt = '0;
        state_nxt = DONE;
      end else begin
        timer_nxt = timer_q + 1'b1;
      end
    end
`endif

    req_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == DONE);
    in_ready_nxt  = state_nxt inside {IDLE, RSP_DEST, RSP_SRC, RSP_VAL, DROP};

    out_nxt = '0;
    case (state_nxt)
      REQ_DEST: begin
        out_nxt.valid = 1'b1;
        out_nxt.data  = FLIT_W'(dest_nxt);
      end
      REQ_HDR: begin
        out_nxt.valid = 1'b1;
        out_nxt.data  = hdr_flit(REQ_READ_REG, id);
      end
      REQ_ADDR: begin
        out_nxt.valid = 1'b1;
        out_nxt.last  = 1'b1;
        out_nxt.data  = addr_nxt;
      end
      default: out_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dest_q         <= '0;
      addr_q         <= '0;
      mis_q          <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_value      <= '0;
      rsp_err        <= 1'b0;
      debug_out      <= '0;
      debug_in_ready <= 1'b1;
`ifdef OSD_REGREAD_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      state          <= state_nxt;
      dest_q         <= dest_nxt;
      addr_q         <= addr_nxt;
      mis_q          <= mis_nxt;
      req_ready      <= req_ready_nxt;
      rsp_valid      <= rsp_valid_nxt;
      rsp_value      <= value_nxt;
      rsp_err        <= err_nxt;
      debug_out      <= out_nxt;
      debug_in_ready <= in_ready_nxt;
`ifdef OSD_REGREAD_TIMEOUT_EN
      timer_q        <= timer_nxt;
`endif
    end
  end

endmodule
